adpcm_packer: RTL and testbench

Downstream stage of the adpcm codec in encode mode (sel_rx=0). It captures each 4-bit code on the codec's ack rising edge and packs four codes per 16-bit word. Every block of BLOCK_NIB codes is preceded by one header word carrying the step index. Words are buffered in a small FIFO and drained through a valid/ready stream toward memory or a serial interface.

---
 rtl/adpcm_packer.sv | 176 +++++++++++++++++
 tb/tb_adpcm_packer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adpcm_packer : packs 4-bit ADPCM codes four per 16-bit word, with a
//                step-index header word per block, into a valid/ready FIFO.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module adpcm_packer #(
   parameter int BLOCK_NIB  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        ack,
   input  logic [3:0]                  tx_adpcm,
   input  logic [7:0]                  tx_idx,
   input  logic                        flush,
   output logic [15:0]                 out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BLOCK_NIB + 1);

   typedef enum logic [0:0] {HDR = 1'b0, DATA = 1'b1} state_t;

   state_t        state_q, state_d;
   logic          ack_d_q, enable_d_q;
   logic [7:0]    last_idx_q;
   logic [1:0]    nib_q, nib_d;
   logic [BW-1:0] blk_q, blk_d;
   logic [15:0]   word_q, word_d;
   logic          hold_q, hold_d;
   logic [15:0]   hold_word_q, hold_word_d;
   logic          push_q, push_d;
   logic [15:0]   push_word_q, push_word_d;
   logic          new_push;
   logic [15:0]   new_word;
   logic          stb, en_rise;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          pop, full, wr;

   assign stb     = ack & ~ack_d_q & enable;
   assign en_rise = enable & ~enable_d_q;

   // Code is applied first, then flush, so a same-cycle flush sees the new code.
   always_comb begin
      state_d     = state_q;
      nib_d       = nib_q;
      blk_d       = blk_q;
      word_d      = word_q;
      new_push    = 1'b0;
      new_word    = 16'h0000;
      hold_d      = 1'b0;
      hold_word_d = 16'h0000;
      if (en_rise) begin
         state_d = HDR;
         nib_d   = 2'd0;
         blk_d   = '0;
         word_d  = 16'h0000;
      end
      if (stb) begin
         if (state_d == HDR) begin
            new_push = 1'b1;
            new_word = {8'hA5, last_idx_q};
            word_d   = {12'h000, tx_adpcm};
            nib_d    = 2'd1;
            blk_d    = BW'(1);
            state_d  = DATA;
         end else begin
            word_d[{nib_d, 2'b00} +: 4] = tx_adpcm;
            if (nib_d == 2'd3) begin
               new_push = 1'b1;
               new_word = word_d;
               word_d   = 16'h0000;
            end
            nib_d = nib_d + 2'd1;
            blk_d = blk_d + BW'(1);
            if (blk_d == BW'(BLOCK_NIB)) begin
               blk_d   = '0;
               state_d = HDR;
            end
         end
      end
      if (flush) begin
         // A header pushed by the same stb defers the padded word by one cycle.
         if (nib_d != 2'd0) begin
            if (new_push) begin
               hold_d      = 1'b1;
               hold_word_d = word_d;
            end else begin
               new_push = 1'b1;
               new_word = word_d;
            end
         end
         word_d  = 16'h0000;
         nib_d   = 2'd0;
         blk_d   = '0;
         state_d = HDR;
      end
      push_d      = new_push | hold_q;
      push_word_d = new_push ? new_word : hold_word_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HDR;
         ack_d_q     <= 1'b0;
         enable_d_q  <= 1'b0;
         last_idx_q  <= 8'h00;
         nib_q       <= 2'd0;
         blk_q       <= '0;
         word_q      <= 16'h0000;
         hold_q      <= 1'b0;
         hold_word_q <= 16'h0000;
         push_q      <= 1'b0;
         push_word_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         ack_d_q     <= ack;
         enable_d_q  <= enable;
         if (stb || en_rise)
            last_idx_q <= tx_idx;
         nib_q       <= nib_d;
         blk_q       <= blk_d;
         word_q      <= word_d;
         hold_q      <= hold_d;
         hold_word_q <= hold_word_d;
         push_q      <= push_d;
         push_word_q <= push_word_d;
      end
   end

   assign pop  = (cnt_q != '0) & out_ready;
   assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign wr   = push_q & (~full | pop);

   always_ff @(posedge clk) begin
      if (wr)
         mem_q[wr_q] <= push_word_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr)
            wr_q <= wr_q + AW'(1);
         if (pop)
            rd_q <= rd_q + AW'(1);
         case ({wr, pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (push_q && full && !pop)
            overflow <= 1'b1;
         else if (en_rise)
            overflow <= 1'b0;
      end
   end

   assign out_valid = (cnt_q != '0);
   assign out_data  = out_valid ? mem_q[rd_q] : 16'h0000;
   assign level     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adpcm_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adpcm_packer : scoreboard bench for adpcm_packer with a queue-based model.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_adpcm_packer;
   localparam int BLOCK_NIB  = 8;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, enable, ack, flush, out_ready;
   logic [3:0]  tx_adpcm;
   logic [7:0]  tx_idx;
   logic [15:0] out_data;
   logic        out_valid, overflow;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   bit rnd_ready = 1'b0;

   logic [15:0] exp_q[$];
   logic [7:0]  m_last;
   int          m_blk;
   logic [3:0]  m_nib[$];

   adpcm_packer #(.BLOCK_NIB(BLOCK_NIB), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ack(ack),
      .tx_adpcm(tx_adpcm), .tx_idx(tx_idx), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted word must match the model's next word.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h required none", out_data);
         end else begin
            check("out_word", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] m_pack();
      logic [15:0] w = 16'h0000;
      foreach (m_nib[k]) w = w | (16'(m_nib[k]) << (4 * k));
      return w;
   endfunction

   task automatic m_code(input logic [3:0] c, input logic [7:0] idx);
      if (m_blk == 0) exp_q.push_back({8'hA5, m_last});
      m_last = idx;
      m_nib.push_back(c);
      m_blk++;
      if (m_nib.size() == 4) begin
         exp_q.push_back(m_pack());
         m_nib.delete();
      end
      if (m_blk == BLOCK_NIB) m_blk = 0;
   endtask

   task automatic m_flush();
      if (m_nib.size() != 0) exp_q.push_back(m_pack());
      m_nib.delete();
      m_blk = 0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [3:0] c, input logic [7:0] idx, input bit fl);
      tx_adpcm = c;
      tx_idx   = idx;
      ack      = 1'b1;
      flush    = fl;
      if (enable) m_code(c, idx);
      if (fl) m_flush();
      tick();
      ack   = 1'b0;
      flush = 1'b0;
      tick();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      m_flush();
      tick();
      flush = 1'b0;
      tick();
   endtask

   task automatic set_enable(input bit v);
      if (v && !enable) begin
         m_last = tx_idx;
         m_blk  = 0;
         m_nib.delete();
      end
      enable = v;
      tick();
   endtask

   task automatic settle(input string nm);
      int t = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || level != 3'd0) && t < 100) begin
         tick();
         t++;
      end
      repeat (3) tick();
      @(negedge clk);
      check({nm, "_sb_empty"}, exp_q.size(), 0);
      check({nm, "_level0"}, {29'h0, level}, 0);
   endtask

   task automatic wait_level_le1();
      int t = 0;
      while (level > 3'd1 && t < 200) begin
         tick();
         t++;
      end
      if (t >= 200) check("level_wait_timeout", {29'h0, level}, 1);
   endtask

   initial begin
      int p0;
      rst = 1'b1; enable = 1'b0; ack = 1'b0; flush = 1'b0; out_ready = 1'b0;
      tx_adpcm = 4'h0; tx_idx = 8'h00;
      m_last = 8'h00; m_blk = 0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'h0, out_valid}, 0);
      check("rst_level", {29'h0, level}, 0);
      check("rst_overflow", {31'h0, overflow}, 0);
      check("rst_out_data", {16'h0, out_data}, 0);

      // 1: basic block with latency check on the first code
      tx_idx = 8'h00;
      set_enable(1'b1);
      out_ready = 1'b1;
      tx_adpcm = 4'h1; tx_idx = 8'h05; ack = 1'b1;
      m_code(4'h1, 8'h05);
      @(negedge clk);
      check("lat_c0_valid", {31'h0, out_valid}, 0);
      tick();
      ack = 1'b0;
      @(negedge clk);
      check("lat_c1_valid", {31'h0, out_valid}, 0);
      tick();
      @(negedge clk);
      check("lat_c2_valid", {31'h0, out_valid}, 1);
      for (int i = 2; i <= 9; i++) send(4'(i), 8'h05, 1'b0);
      settle("t1");

      // 2: flush of a partial word, flush at a word boundary, flush with stb
      do_flush();
      send(4'hA, 8'h05, 1'b0);
      send(4'hB, 8'h05, 1'b0);
      do_flush();
      for (int i = 12; i <= 15; i++) send(4'(i), 8'h06, 1'b0);
      do_flush();
      settle("t2");
      send(4'h1, 8'h07, 1'b1);
      settle("t2b");

      // 3: backpressure and overflow
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(4'(i + 1), 8'h10, 1'b0);
      @(negedge clk);
      check("bp_level3", {29'h0, level}, 3);
      check("bp_no_ovf", {31'h0, overflow}, 0);
      for (int i = 0; i < 8; i++) send(4'(i + 3), 8'h20, 1'b0);
      @(negedge clk);
      check("bp_level4", {29'h0, level}, 4);
      check("bp_ovf", {31'h0, overflow}, 1);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      p0 = pops;
      settle("t3");
      check("bp_drain_count", pops - p0, 4);

      // 4: push and pop together while full
      set_enable(1'b0);
      tx_idx = 8'h3C;
      set_enable(1'b1);
      @(negedge clk);
      check("t4_ovf_cleared", {31'h0, overflow}, 0);
      out_ready = 1'b0;
      for (int i = 0; i < 11; i++) send(4'(i + 2), 8'h40, 1'b0);
      @(negedge clk);
      check("t4_full", {29'h0, level}, 4);
      tx_adpcm = 4'hE; tx_idx = 8'h41; ack = 1'b1;
      m_code(4'hE, 8'h41);
      tick();
      ack = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      check("t4_level_kept", {29'h0, level}, 4);
      check("t4_no_ovf", {31'h0, overflow}, 0);
      settle("t4");

      // 5: held ack, disabled code, enable re-rise
      set_enable(1'b0);
      tx_idx = 8'h11;
      set_enable(1'b1);
      tx_adpcm = 4'h6; tx_idx = 8'h22; ack = 1'b1;
      m_code(4'h6, 8'h22);
      repeat (10) tick();
      ack = 1'b0;
      tick();
      settle("t5a");
      set_enable(1'b0);
      send(4'h7, 8'h99, 1'b0);
      tx_idx = 8'h33;
      set_enable(1'b1);
      @(negedge clk);
      check("t5_ovf_clear", {31'h0, overflow}, 0);
      for (int i = 8; i <= 11; i++) send(4'(i), 8'h44, 1'b0);
      settle("t5b");

      // 6: reset mid-block with two words queued
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send(4'(i), 8'h55, 1'b0);
      @(negedge clk);
      check("t6_level2", {29'h0, level}, 2);
      tx_idx = 8'h00;
      rst = 1'b1;
      exp_q.delete();
      m_nib.delete();
      m_blk  = 0;
      m_last = 8'h00;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_valid0", {31'h0, out_valid}, 0);
      check("t6_level0", {29'h0, level}, 0);
      out_ready = 1'b1;
      send(4'h5, 8'h10, 1'b0);
      settle("t6");

      // randomized traffic against the model
      rnd_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 15);
         wait_level_le1();
         if (r == 0) begin
            do_flush();
         end else if (r == 1) begin
            set_enable(1'b0);
            if ($urandom_range(0, 1) == 1)
               send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
            tx_idx = 8'($urandom_range(0, 255));
            set_enable(1'b1);
         end else begin
            send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), r == 2);
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      rnd_ready = 1'b0;
      settle("rand");
      check("rand_no_ovf", {31'h0, overflow}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
